mmcm_drp_sequencer: RTL and testbench

//  Reprograms an MMCME2_ADV at runtime via its DRP port. On i_start: hold MMCM in reset,

---
 rtl/mmcm_drp_pkg.sv | 39 +++
 rtl/mmcm_drp_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_mmcm_drp_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration sequencer.
package mmcm_drp_pkg;

    // One table entry: register address, keep-mask (1 = keep existing bit), new data.
    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ASSERT_RST = 4'd1,
        S_FETCH      = 4'd2,
        S_READ       = 4'd3,
        S_WAIT_RD    = 4'd4,
        S_WRITE      = 4'd5,
        S_WAIT_WR    = 4'd6,
        S_RELEASE    = 4'd7,
        S_WAIT_LOCK  = 4'd8,
        S_DONE       = 4'd9,
        S_ERR        = 4'd10
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_DRP_TMO  = 2'b01;
    localparam logic [1:0] ERR_LOCK_TMO = 2'b10;

    // LOCKED seen in the first cycles after reset release may be stale.
    localparam int LOCK_IGNORE_CYCLES = 2;

    // Read-modify-write merge: mask bit 1 keeps the bit read back from the MMCM.
    function automatic logic [15:0] drp_merge(input logic [15:0] rd_val,
                                              input logic [15:0] mask,
                                              input logic [15:0] data);
        return (rd_val & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_sequencer.sv
// Runtime MMCME2_ADV reprogramming: holds the MMCM in reset, read-modify-writes
// every table entry over DRP, releases reset and waits for LOCKED.
module mmcm_drp_sequencer
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_ENTRIES  = 23,
    parameter int RST_CYCLES   = 8,
    parameter int DRP_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_locked,
    output logic [4:0]  o_tbl_idx,
    input  logic [38:0] i_tbl_entry,
    output logic [6:0]  o_drp_addr,
    output logic [15:0] o_drp_di,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic        o_mmcm_rst,
    input  logic        i_mmcm_locked
);

    // One shared counter serves reset hold, DRP timeouts and lock timeout.
    localparam int TMR_MAX0 = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_MAX  = (RST_CYCLES > TMR_MAX0) ? RST_CYCLES : TMR_MAX0;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRP_LAST  = TMR_W'(DRP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_IGN  = TMR_W'(LOCK_IGNORE_CYCLES);
    localparam logic [4:0]       LAST_IDX  = 5'(NUM_ENTRIES - 1);

    drp_entry_t w_entry;
    assign w_entry = drp_entry_t'(i_tbl_entry);

    state_t           r_state,    w_state_nxt;
    logic [TMR_W-1:0] r_tmr,      w_tmr_nxt;
    logic [4:0]       r_idx,      w_idx_nxt;
    logic             r_fetch_ph, w_fetch_ph_nxt;
    logic [15:0]      r_mask,     w_mask_nxt;
    logic [15:0]      r_data,     w_data_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_err,      w_err_nxt;
    logic [1:0]       r_err_code, w_err_code_nxt;
    logic [6:0]       r_drp_addr, w_drp_addr_nxt;
    logic [15:0]      r_drp_di,   w_drp_di_nxt;
    logic             r_den,      w_den_nxt;
    logic             r_dwe,      w_dwe_nxt;
    logic             r_mmcm_rst, w_mmcm_rst_nxt;
    logic             r_locked,   w_locked_nxt;

    // Next-state and next-output logic; every output is the register of its next value.
    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_nxt      = r_tmr;
        w_idx_nxt      = r_idx;
        w_fetch_ph_nxt = r_fetch_ph;
        w_mask_nxt     = r_mask;
        w_data_nxt     = r_data;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;
        w_drp_addr_nxt = r_drp_addr;
        w_drp_di_nxt   = r_drp_di;
        w_den_nxt      = 1'b0;
        w_dwe_nxt      = 1'b0;
        w_mmcm_rst_nxt = r_mmcm_rst;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = S_ASSERT_RST;
                    w_busy_nxt     = 1'b1;
                    w_err_code_nxt = ERR_NONE;
                    w_idx_nxt      = 5'd0;
                    w_tmr_nxt      = '0;
                    w_mmcm_rst_nxt = 1'b1;
                end
            end
            S_ASSERT_RST: begin
                if (r_tmr == RST_LAST) begin
                    w_state_nxt    = S_FETCH;
                    w_tmr_nxt      = '0;
                    w_fetch_ph_nxt = 1'b0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_FETCH: begin
                // Phase 0 presents the index, phase 1 captures the ROM output.
                if (!r_fetch_ph) begin
                    w_fetch_ph_nxt = 1'b1;
                end else begin
                    w_mask_nxt     = w_entry.mask;
                    w_data_nxt     = w_entry.data;
                    w_drp_addr_nxt = w_entry.addr;
                    w_den_nxt      = 1'b1;
                    w_state_nxt    = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_WAIT_RD;
                w_tmr_nxt   = '0;
            end
            S_WAIT_RD: begin
                if (i_drp_drdy) begin
                    w_drp_di_nxt = drp_merge(i_drp_do, r_mask, r_data);
                    w_den_nxt    = 1'b1;
                    w_dwe_nxt    = 1'b1;
                    w_state_nxt  = S_WRITE;
                end else if (r_tmr == DRP_LAST) begin
                    // MMCM stays in reset: a partial configuration must not run.
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_err_code_nxt = ERR_DRP_TMO;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_WAIT_WR;
                w_tmr_nxt   = '0;
            end
            S_WAIT_WR: begin
                if (i_drp_drdy) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt    = S_RELEASE;
                        w_mmcm_rst_nxt = 1'b0;
                    end else begin
                        w_idx_nxt      = r_idx + 5'd1;
                        w_fetch_ph_nxt = 1'b0;
                        w_state_nxt    = S_FETCH;
                    end
                end else if (r_tmr == DRP_LAST) begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_err_code_nxt = ERR_DRP_TMO;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_WAIT_LOCK;
                w_tmr_nxt   = '0;
            end
            S_WAIT_LOCK: begin
                if (i_mmcm_locked && (r_tmr >= LOCK_IGN)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else if (r_tmr == LOCK_LAST) begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_err_code_nxt = ERR_LOCK_TMO;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // LOCKED is meaningless to the user while a reconfiguration is running.
        w_locked_nxt = i_mmcm_locked & ~w_busy_nxt;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_idx      <= 5'd0;
            r_fetch_ph <= 1'b0;
            r_mask     <= 16'h0;
            r_data     <= 16'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_drp_addr <= 7'h0;
            r_drp_di   <= 16'h0;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_mmcm_rst <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_idx      <= w_idx_nxt;
            r_fetch_ph <= w_fetch_ph_nxt;
            r_mask     <= w_mask_nxt;
            r_data     <= w_data_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_drp_addr <= w_drp_addr_nxt;
            r_drp_di   <= w_drp_di_nxt;
            r_den      <= w_den_nxt;
            r_dwe      <= w_dwe_nxt;
            r_mmcm_rst <= w_mmcm_rst_nxt;
            r_locked   <= w_locked_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_locked   = r_locked;
    assign o_tbl_idx  = r_idx;
    assign o_drp_addr = r_drp_addr;
    assign o_drp_di   = r_drp_di;
    assign o_drp_den  = r_den;
    assign o_drp_dwe  = r_dwe;
    assign o_mmcm_rst = r_mmcm_rst;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: behavioural MMCM DRP/LOCKED model, external table
// ROM, and a scoreboard of expected DRP accesses.
module tb_mmcm_drp_sequencer;
    import mmcm_drp_pkg::*;

    localparam int N        = 23;
    localparam int RSTC     = 8;
    localparam int DT       = 40;
    localparam int LT       = 300;
    localparam int LOCK_LAT = 50;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic        busy, done, err, locked, den, dwe, mmcm_rst;
    logic [1:0]  err_code;
    logic [4:0]  tbl_idx;
    logic [38:0] tbl_entry = '0;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] m_do = 16'h0;
    logic        m_drdy = 1'b0, stray = 1'b0, drdy;
    logic        m_locked = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign drdy = m_drdy | stray;

    mmcm_drp_sequencer #(
        .NUM_ENTRIES(N), .RST_CYCLES(RSTC), .DRP_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(err_code),
        .o_locked(locked), .o_tbl_idx(tbl_idx), .i_tbl_entry(tbl_entry),
        .o_drp_addr(drp_addr), .o_drp_di(drp_di), .o_drp_den(den), .o_drp_dwe(dwe),
        .i_drp_do(m_do), .i_drp_drdy(drdy), .o_mmcm_rst(mmcm_rst),
        .i_mmcm_locked(m_locked)
    );

    // External table ROM, one cycle read latency.
    logic [38:0] rom [32];
    always @(posedge clk) tbl_entry <= rom[tbl_idx];

    // MMCM DRP register file model: DRDY three cycles after DEN.
    logic [15:0] mem      [128];
    logic [15:0] init_val [128];
    logic [15:0] exp_mem  [128];
    logic        init_req = 1'b0;
    int          drop_access = -1;
    logic        pend = 1'b0, pwe = 1'b0;
    int          pcnt = 0, acc = 0;
    logic [6:0]  paddr = '0;
    logic [15:0] pdi = '0;

    always @(posedge clk) begin
        m_drdy <= 1'b0;
        if (init_req) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val[i];
            acc  <= 0;
            pend <= 1'b0;
        end else if (den) begin
            pend  <= (acc != drop_access);
            pcnt  <= 2;
            pwe   <= dwe;
            paddr <= drp_addr;
            pdi   <= drp_di;
            acc   <= acc + 1;
        end else if (pend) begin
            if (pcnt == 1) begin
                pend   <= 1'b0;
                m_drdy <= 1'b1;
                if (pwe) mem[paddr] <= pdi;
                else     m_do <= mem[paddr];
            end else begin
                pcnt <= pcnt - 1;
            end
        end
    end

    // LOCKED model: rises LOCK_LAT cycles after RST falls. In stale mode LOCKED
    // survives the reset and only drops two cycles after RST falls.
    logic lock_en = 1'b1, stale_mode = 1'b0;
    int   lcnt = 0;
    always @(posedge clk) begin
        if (mmcm_rst) begin
            lcnt <= 0;
            if (!stale_mode) m_locked <= 1'b0;
        end else if (lcnt < LOCK_LAT) begin
            lcnt <= lcnt + 1;
            if (stale_mode && lcnt == 1) m_locked <= 1'b0;
            if (lcnt == LOCK_LAT - 1) m_locked <= lock_en;
        end
    end

    int   n_checks = 0, n_fail = 0;
    int   rst_fall_cyc = 0, last_den_cyc = 0, n_den = 0;
    acc_t exp_q[$];

    task automatic load_mem(input bit rnd, input logic [15:0] fill);
        for (int i = 0; i < 128; i++) begin
            init_val[i] = rnd ? 16'($urandom) : fill;
            exp_mem[i]  = init_val[i];
        end
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic set_mem(input int a, input logic [15:0] v);
        init_val[a] = v;
        exp_mem[a]  = v;
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic random_table();
        for (int i = 0; i < N; i++)
            rom[i] = {7'(16 + 3 * i), 16'($urandom), 16'($urandom)};
    endtask

    // Push the accesses expected for entries 0..last (last entry read-only if asked).
    task automatic expect_seq(input int last, input bit rd_only_last);
        acc_t e;
        logic [6:0]  a;
        logic [15:0] m, d;
        exp_q.delete();
        for (int i = 0; i <= last; i++) begin
            a = rom[i][38:32];
            m = rom[i][31:16];
            d = rom[i][15:0];
            e.we = 1'b0; e.addr = a; e.di = 16'h0;
            exp_q.push_back(e);
            if (!(rd_only_last && i == last)) begin
                e.we = 1'b1;
                e.di = (exp_mem[a] & m) | (d & ~m);
                exp_mem[a] = e.di;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Step the DUT, scoring each DRP access against the expected queue.
    // status: 0 budget expired, 1 done, 2 err, 3 stopped after stop_den accesses.
    task automatic run_seq(input int max_cyc, input int stop_den, output int status, output int ev_cyc);
        int   dens;
        logic prev_rst;
        acc_t e;
        dens = 0; status = 0; ev_cyc = 0; prev_rst = mmcm_rst;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (prev_rst && !mmcm_rst) rst_fall_cyc = cyc;
            prev_rst = mmcm_rst;
            if (den) begin
                dens++; n_den++; last_den_cyc = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL drp_access: got unexpected we=%0b addr=%h di=%h, required none", dwe, drp_addr, drp_di);
                end else begin
                    e = exp_q.pop_front();
                    if (dwe !== e.we || drp_addr !== e.addr || (e.we && drp_di !== e.di)) begin
                        n_fail++;
                        $display("FAIL drp_access: got we=%0b addr=%h di=%h, required we=%0b addr=%h di=%h",
                                 dwe, drp_addr, drp_di, e.we, e.addr, e.di);
                    end
                end
                n_checks++;
                if (mmcm_rst !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_during_den: got %b, required 1", mmcm_rst);
                end
                if (stop_den > 0 && dens == stop_den) begin
                    status = 3; ev_cyc = cyc; return;
                end
            end
            if (done) begin status = 1; ev_cyc = cyc; return; end
            if (err)  begin status = 2; ev_cyc = cyc; return; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err, den, dwe, mmcm_rst, locked} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000000", {busy, done, err, den, dwe, mmcm_rst, locked});
        end
        n_checks++;
        if (err_code !== ERR_NONE || tbl_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_code_idx: got code=%b idx=%0d, required 00/0", err_code, tbl_idx);
        end
        n_checks++;
        if (drp_addr !== 7'h0 || drp_di !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_drp_bus: got addr=%h di=%h, required 0/0", drp_addr, drp_di);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single_rmw();
        int st, ev;
        rom[0] = {7'h08, 16'h1000, 16'h0041};
        for (int i = 1; i < N; i++) rom[i] = {7'h08, 16'hFFFF, 16'h0000};
        load_mem(1'b0, 16'h0000);
        set_mem(8, 16'hFFFF);
        expect_seq(N - 1, 1'b0);
        pulse_start();
        run_seq(5000, 0, st, ev);
        n_checks++;
        if (st !== 1) begin n_fail++; $display("FAIL single_done: got status %0d, required 1", st); end
        n_checks++;
        if (ev - rst_fall_cyc !== LOCK_LAT + 1) begin
            n_fail++; $display("FAIL single_lock_latency: got %0d, required %0d", ev - rst_fall_cyc, LOCK_LAT + 1);
        end
        n_checks++;
        if (mem[8] !== 16'h1041) begin n_fail++; $display("FAIL single_reg: got %h, required 1041", mem[8]); end
        n_checks++;
        if (err_code !== ERR_NONE) begin n_fail++; $display("FAIL single_code: got %b, required 00", err_code); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_done_once: got done=%b busy=%b, required 0/0", done, busy);
        end
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %b, required 1", locked); end
    endtask

    task automatic test_full_table();
        int st, ev, base, bad;
        random_table();
        load_mem(1'b1, 16'h0);
        expect_seq(N - 1, 1'b0);
        base = n_den;
        pulse_start();
        run_seq(5000, 0, st, ev);
        n_checks++;
        if (st !== 1) begin n_fail++; $display("FAIL full_done: got status %0d, required 1", st); end
        n_checks++;
        if (n_den - base !== 2 * N || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL full_access_count: got %0d (left %0d), required %0d", n_den - base, exp_q.size(), 2 * N);
        end
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL full_regs: got %0d differing regs, required 0", bad); end
    endtask

    task automatic test_stale_lock_stray();
        int st, ev;
        stale_mode = 1'b1;
        for (int k = 0; k < 200 && !locked; k++) @(negedge clk);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL stale_idle_locked: got %b, required 1", locked); end
        load_mem(1'b1, 16'h0);
        expect_seq(N - 1, 1'b0);
        pulse_start();
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL stale_locked_busy: got %b, required 0", locked); end
        repeat (RSTC) @(negedge clk);
        stray = 1'b1;
        @(negedge clk) stray = 1'b0;
        run_seq(5000, 0, st, ev);
        n_checks++;
        if (st !== 1) begin n_fail++; $display("FAIL stale_done: got status %0d, required 1", st); end
        n_checks++;
        if (ev - rst_fall_cyc !== LOCK_LAT + 1) begin
            n_fail++; $display("FAIL stale_fresh_lock: got %0d, required %0d", ev - rst_fall_cyc, LOCK_LAT + 1);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stale_accesses_left: got %0d, required 0", exp_q.size()); end
        stale_mode = 1'b0;
    endtask

    task automatic test_drp_timeout();
        int st, ev;
        logic [6:0] a5;
        random_table();
        load_mem(1'b1, 16'h0);
        expect_seq(4, 1'b1);
        drop_access = 8;
        pulse_start();
        run_seq(5000, 0, st, ev);
        n_checks++;
        if (st !== 2) begin n_fail++; $display("FAIL drp_tmo_err: got status %0d, required 2", st); end
        n_checks++;
        if (ev - last_den_cyc !== DT + 1) begin
            n_fail++; $display("FAIL drp_tmo_latency: got %0d, required %0d", ev - last_den_cyc, DT + 1);
        end
        n_checks++;
        if (err_code !== ERR_DRP_TMO || mmcm_rst !== 1'b1) begin
            n_fail++; $display("FAIL drp_tmo_code_rst: got code=%b rst=%b, required 01/1", err_code, mmcm_rst);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || mmcm_rst !== 1'b1) begin
            n_fail++; $display("FAIL drp_tmo_after: got err=%b busy=%b rst=%b, required 0/0/1", err, busy, mmcm_rst);
        end
        a5 = rom[5][38:32];
        n_checks++;
        if (mem[a5] !== init_val[a5]) begin n_fail++; $display("FAIL drp_tmo_entry5: got %h, required %h", mem[a5], init_val[a5]); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL drp_tmo_accesses_left: got %0d, required 0", exp_q.size()); end
        drop_access = -1;
    endtask

    task automatic test_lock_timeout();
        int st, ev;
        lock_en = 1'b0;
        load_mem(1'b1, 16'h0);
        expect_seq(N - 1, 1'b0);
        pulse_start();
        run_seq(5000, 0, st, ev);
        n_checks++;
        if (st !== 2) begin n_fail++; $display("FAIL lock_tmo_err: got status %0d, required 2", st); end
        n_checks++;
        if (ev - rst_fall_cyc !== LT + 1) begin
            n_fail++; $display("FAIL lock_tmo_latency: got %0d, required %0d", ev - rst_fall_cyc, LT + 1);
        end
        n_checks++;
        if (err_code !== ERR_LOCK_TMO || mmcm_rst !== 1'b0 || locked !== 1'b0) begin
            n_fail++; $display("FAIL lock_tmo_state: got code=%b rst=%b locked=%b, required 10/0/0", err_code, mmcm_rst, locked);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL lock_tmo_accesses_left: got %0d, required 0", exp_q.size()); end
        lock_en = 1'b1;
    endtask

    task automatic test_start_ignored_reset();
        int st, ev;
        load_mem(1'b1, 16'h0);
        expect_seq(N - 1, 1'b0);
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_start();
        run_seq(2000, 2, st, ev);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        run_seq(2000, 1, st, ev);
        n_checks++;
        if (st !== 3) begin n_fail++; $display("FAIL busy_start_reached_rd: got status %0d, required 3", st); end
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, den, dwe, mmcm_rst, locked} !== 7'b0) begin
            n_fail++; $display("FAIL midseq_reset_flags: got %b, required 0000000", {busy, done, err, den, dwe, mmcm_rst, locked});
        end
        n_checks++;
        if (err_code !== ERR_NONE || tbl_idx !== 5'd0 || drp_addr !== 7'h0 || drp_di !== 16'h0) begin
            n_fail++; $display("FAIL midseq_reset_bus: got code=%b idx=%0d addr=%h di=%h, required zeros", err_code, tbl_idx, drp_addr, drp_di);
        end
        rst_n = 1'b1;
        exp_q.delete();
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || den !== 1'b0) begin
            n_fail++; $display("FAIL midseq_stays_idle: got busy=%b den=%b, required 0/0", busy, den);
        end
        load_mem(1'b1, 16'h0);
        expect_seq(N - 1, 1'b0);
        pulse_start();
        run_seq(5000, 0, st, ev);
        n_checks++;
        if (st !== 1 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL restart_done: got status %0d left %0d, required 1/0", st, exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = '0;
        test_reset();
        test_single_rmw();
        test_full_table();
        test_stale_lock_stray();
        test_drp_timeout();
        test_lock_timeout();
        test_start_ignored_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
